ram_fifo_ctrl: RTL

- FIFO controller that sits directly upstream of the 128x4 single-port RAM.
- Drives the RAM's addr, w_data and enb, and consumes its combinational r_data.
- Converts a valid/ready push stream and a valid/ready pop stream into one RAM access per cycle, and registers read data into an output stage.
- Arbitrates write vs read round-robin, because the RAM port can either write (enb=1, clocked) or read (enb=0, combinational) in a given cycle, never both.

---
 rtl/ram_fifo_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram_fifo_ctrl : valid/ready FIFO controller for a single-port RAM, one
//                 round-robin arbitrated write or read per cycle. Rev 1.0
// ---------------------------------------------------------------------------
module ram_fifo_ctrl #(
   parameter int AW = 7,
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_w_data,
   output logic          ram_enb,
   input  logic [DW-1:0] ram_r_data,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
   localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   ram_cnt_q, ram_cnt_d;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic          prio_q, prio_d;

   logic wreq, rreq, wr_gnt, rd_gnt;

   assign full  = (ram_cnt_q == DEPTH);
   assign count = ram_cnt_q + {{AW{1'b0}}, out_valid_q};
   assign empty = (count == '0);

   // rst gates the write request so nothing is granted while reset is held
   assign wreq   = in_valid && !full && !rst;
   assign rreq   = (ram_cnt_q != '0) && (!out_valid_q || out_ready);
   assign wr_gnt = wreq && (!rreq || prio_q);
   assign rd_gnt = rreq && (!wreq || !prio_q);

   assign in_ready  = wr_gnt;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      ram_cnt_d   = ram_cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      prio_d      = prio_q;
      ram_enb     = 1'b0;
      ram_addr    = rd_ptr_q;
      ram_w_data  = '0;

      if (wr_gnt) begin
         ram_enb    = 1'b1;
         ram_addr   = wr_ptr_q;
         ram_w_data = in_data;
         wr_ptr_d   = wr_ptr_q + PTR_ONE;
         ram_cnt_d  = ram_cnt_q + CNT_ONE;
      end

      if (rd_gnt) begin
         rd_ptr_d    = rd_ptr_q + PTR_ONE;
         ram_cnt_d   = ram_cnt_q - CNT_ONE;
         out_data_d  = ram_r_data;
         out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      // a tie hands priority to whichever side lost it
      if (wreq && rreq) begin
         prio_d = !prio_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         ram_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         prio_q      <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         ram_cnt_q   <= ram_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         prio_q      <= prio_d;
      end
   end

endmodule
`default_nettype wire
